// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I integer core: fetch, decode, execute and retire one instruction per clock.
// Load/store sizing and extension are handled by an external organizer driven from Mem_type_sel.
module rv32i_single_cycle_core #(
   parameter int          size     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] instruction,
   input  logic [size-1:0] Data_in,
   output logic [size-1:0] Data_out,
   output logic [size-1:0] Addr_out,
   output logic [size-1:0] PC_Addr,
   output logic [2:0]      Mem_type_sel,
   output logic            Mem_write
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASS_B
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_LINK
   } wb_sel_t;

   logic [size-1:0] r_pc;
   logic [size-1:0] r_regs [0:31];

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [2:0]      w_funct3;
   logic            w_funct7b5;

   logic [size-1:0] w_imm_i;
   logic [size-1:0] w_imm_s;
   logic [size-1:0] w_imm_b;
   logic [size-1:0] w_imm_u;
   logic [size-1:0] w_imm_j;

   logic [size-1:0] w_rs1_val;
   logic [size-1:0] w_rs2_val;

   alu_op_t         w_alu_op;
   wb_sel_t         w_wb_sel;
   logic            w_src_a_pc;
   logic            w_src_b_imm;
   logic [size-1:0] w_imm;
   logic            w_reg_we;
   logic            w_is_branch;
   logic            w_is_jal;
   logic            w_is_jalr;
   logic            w_mem_write;
   logic [2:0]      w_mem_type;

   logic [size-1:0] w_alu_a;
   logic [size-1:0] w_alu_b;
   logic [4:0]      w_shamt;
   logic [size-1:0] w_alu_result;

   logic            w_br_eq;
   logic            w_br_lt;
   logic            w_br_ltu;
   logic            w_br_taken;

   logic [size-1:0] w_pc_plus4;
   logic [size-1:0] w_next_pc;
   logic [size-1:0] w_wb_data;

   assign w_opcode   = instruction[6:0];
   assign w_rd       = instruction[11:7];
   assign w_funct3   = instruction[14:12];
   assign w_rs1      = instruction[19:15];
   assign w_rs2      = instruction[24:20];
   assign w_funct7b5 = instruction[30];

   assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
   assign w_imm_u = {instruction[31:12], 12'b0};
   assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

   // x0 is hardwired to zero regardless of the storage contents
   assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

   function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      w_alu_op    = ALU_ADD;
      w_wb_sel    = WB_ALU;
      w_src_a_pc  = 1'b0;
      w_src_b_imm = 1'b1;
      w_imm       = w_imm_i;
      w_reg_we    = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      w_mem_write = 1'b0;
      w_mem_type  = 3'b010;
      case (w_opcode)
         OPC_LUI: begin
            w_alu_op = ALU_PASS_B;
            w_imm    = w_imm_u;
            w_reg_we = 1'b1;
         end
         OPC_AUIPC: begin
            w_src_a_pc = 1'b1;
            w_imm      = w_imm_u;
            w_reg_we   = 1'b1;
         end
         OPC_JAL: begin
            w_is_jal = 1'b1;
            w_reg_we = 1'b1;
            w_wb_sel = WB_LINK;
         end
         OPC_JALR: begin
            w_is_jalr = 1'b1;
            w_reg_we  = 1'b1;
            w_wb_sel  = WB_LINK;
         end
         OPC_BRANCH: begin
            w_is_branch = 1'b1;
            w_src_b_imm = 1'b0;
            w_alu_op    = ALU_SUB;
         end
         OPC_LOAD: begin
            w_reg_we   = 1'b1;
            w_wb_sel   = WB_MEM;
            w_mem_type = w_funct3;
         end
         OPC_STORE: begin
            w_imm       = w_imm_s;
            w_mem_write = 1'b1;
            w_mem_type  = w_funct3;
         end
         // bit 30 of an I-immediate only selects SRAI; for ADDI it is ordinary immediate data
         OPC_OPIMM: begin
            w_reg_we = 1'b1;
            w_alu_op = f3_to_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7b5);
         end
         OPC_OP: begin
            w_src_b_imm = 1'b0;
            w_reg_we    = 1'b1;
            w_alu_op    = f3_to_alu(w_funct3, w_funct7b5);
         end
         default: begin
            w_reg_we = 1'b0;
         end
      endcase
   end

   assign w_alu_a = w_src_a_pc  ? r_pc  : w_rs1_val;
   assign w_alu_b = w_src_b_imm ? w_imm : w_rs2_val;
   assign w_shamt = w_alu_b[4:0];

   always_comb begin
      w_alu_result = '0;
      case (w_alu_op)
         ALU_ADD:    w_alu_result = w_alu_a + w_alu_b;
         ALU_SUB:    w_alu_result = w_alu_a - w_alu_b;
         ALU_SLL:    w_alu_result = w_alu_a << w_shamt;
         ALU_SLT:    w_alu_result = {{(size-1){1'b0}}, $signed(w_alu_a) < $signed(w_alu_b)};
         ALU_SLTU:   w_alu_result = {{(size-1){1'b0}}, w_alu_a < w_alu_b};
         ALU_XOR:    w_alu_result = w_alu_a ^ w_alu_b;
         ALU_SRL:    w_alu_result = w_alu_a >> w_shamt;
         ALU_SRA:    w_alu_result = $unsigned($signed(w_alu_a) >>> w_shamt);
         ALU_OR:     w_alu_result = w_alu_a | w_alu_b;
         ALU_AND:    w_alu_result = w_alu_a & w_alu_b;
         ALU_PASS_B: w_alu_result = w_alu_b;
         default:    w_alu_result = '0;
      endcase
   end

   assign w_br_eq  = (w_rs1_val == w_rs2_val);
   assign w_br_lt  = ($signed(w_rs1_val) < $signed(w_rs2_val));
   assign w_br_ltu = (w_rs1_val < w_rs2_val);

   always_comb begin
      w_br_taken = 1'b0;
      case (w_funct3)
         3'b000:  w_br_taken = w_br_eq;
         3'b001:  w_br_taken = !w_br_eq;
         3'b100:  w_br_taken = w_br_lt;
         3'b101:  w_br_taken = !w_br_lt;
         3'b110:  w_br_taken = w_br_ltu;
         3'b111:  w_br_taken = !w_br_ltu;
         default: w_br_taken = 1'b0;
      endcase
   end

   assign w_pc_plus4 = r_pc + 32'd4;

   // JALR reuses the ALU sum rs1+I-imm, so a JALR with rd==rs1 sees the old rs1
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (w_is_jal) begin
         w_next_pc = r_pc + w_imm_j;
      end else if (w_is_jalr) begin
         w_next_pc = w_alu_result & ~32'd1;
      end else if (w_is_branch && w_br_taken) begin
         w_next_pc = r_pc + w_imm_b;
      end
   end

   always_comb begin
      w_wb_data = w_alu_result;
      case (w_wb_sel)
         WB_MEM:  w_wb_data = Data_in;
         WB_LINK: w_wb_data = w_pc_plus4;
         default: w_wb_data = w_alu_result;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_reg_we && (w_rd != 5'd0)) begin
         r_regs[w_rd] <= w_wb_data;
      end
   end

   assign PC_Addr      = {2'b00, r_pc[31:2]};
   assign Addr_out     = w_alu_result;
   assign Data_out     = w_rs2_val;
   assign Mem_type_sel = w_mem_type;
   assign Mem_write    = w_mem_write;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: directed vector table, async reset sequence and
// random instruction streams checked against an instruction-level reference model.
module tb_rv32i_single_cycle_core;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] Data_in;
   logic [31:0] Data_out;
   logic [31:0] Addr_out;
   logic [31:0] PC_Addr;
   logic [2:0]  Mem_type_sel;
   logic        Mem_write;

   int n_tests = 0;
   int n_fail  = 0;

   rv32i_single_cycle_core #(.size(32), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .instruction  (instruction),
      .Data_in      (Data_in),
      .Data_out     (Data_out),
      .Addr_out     (Addr_out),
      .PC_Addr      (PC_Addr),
      .Mem_type_sel (Mem_type_sel),
      .Mem_write    (Mem_write)
   );

   // ---------------- clock / reset / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- instruction encoders ----------------
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      logic [31:0] v;
      v = imm;
      return {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm20[19:0], rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_regs [0:31];
   logic [31:0] m_pc;

   typedef struct {
      logic [31:0] npc;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wv;
      logic        chk_addr;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [2:0]  mts;
      logic        mw;
   } model_t;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc = 32'h0;
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b, input logic alt);
      int sh;
      sh = int'(b % 32);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << sh;
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic model_t ref_exec(input logic [31:0] ins, input logic [31:0] din);
      model_t      m;
      logic [31:0] a, b, ii, is, ib, iu, ij;
      logic [2:0]  f3;
      logic        taken;
      a  = m_regs[ins[19:15]];
      b  = m_regs[ins[24:20]];
      f3 = ins[14:12];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'h000};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      m.npc = m_pc + 32'd4;
      m.we = 1'b0; m.rd = ins[11:7]; m.wv = 32'h0;
      m.chk_addr = 1'b0; m.addr = 32'h0; m.dout = b; m.mts = 3'b010; m.mw = 1'b0;
      case (ins[6:0])
         7'b0110111: begin m.we = 1'b1; m.wv = iu; end
         7'b0010111: begin m.we = 1'b1; m.wv = m_pc + iu; end
         7'b1101111: begin m.we = 1'b1; m.wv = m_pc + 32'd4; m.npc = m_pc + ij; end
         7'b1100111: begin m.we = 1'b1; m.wv = m_pc + 32'd4; m.npc = (a + ii) & 32'hFFFF_FFFE; end
         7'b1100011: begin
            case (f3)
               3'd0:    taken = (a == b);
               3'd1:    taken = (a != b);
               3'd4:    taken = ($signed(a) < $signed(b));
               3'd5:    taken = ($signed(a) >= $signed(b));
               3'd6:    taken = (a < b);
               3'd7:    taken = (a >= b);
               default: taken = 1'b0;
            endcase
            if (taken) m.npc = m_pc + ib;
         end
         7'b0000011: begin
            m.we = 1'b1; m.wv = din; m.chk_addr = 1'b1; m.addr = a + ii; m.mts = f3;
         end
         7'b0100011: begin
            m.chk_addr = 1'b1; m.addr = a + is; m.mts = f3; m.mw = 1'b1;
         end
         7'b0010011: begin
            m.we = 1'b1; m.chk_addr = 1'b1;
            m.wv = ref_alu(f3, a, ii, (f3 == 3'd5) && ins[30]);
            m.addr = m.wv;
         end
         7'b0110011: begin
            m.we = 1'b1; m.chk_addr = 1'b1;
            m.wv = ref_alu(f3, a, b, ins[30]);
            m.addr = m.wv;
         end
         default: m.we = 1'b0;
      endcase
      return m;
   endfunction

   // ---------------- driver / checker ----------------
   logic [31:0] s_pca, s_addr, s_dout;
   logic [2:0]  s_mts;
   logic        s_mw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive one instruction on the falling edge; it retires on the following rising edge.
   task automatic step(input logic [31:0] ins, input logic [31:0] din);
      model_t m;
      @(negedge clk);
      instruction = ins;
      Data_in     = din;
      #1;
      m = ref_exec(ins, din);
      s_pca = PC_Addr; s_addr = Addr_out; s_dout = Data_out; s_mts = Mem_type_sel; s_mw = Mem_write;
      check("model_pc_addr", PC_Addr, {2'b00, m_pc[31:2]});
      check("model_mem_write", {31'h0, Mem_write}, {31'h0, m.mw});
      check("model_mem_type", {29'h0, Mem_type_sel}, {29'h0, m.mts});
      if (m.chk_addr) check("model_addr_out", Addr_out, m.addr);
      if (m.mw) check("model_data_out", Data_out, m.dout);
      if (m.we && (m.rd != 5'd0)) m_regs[m.rd] = m.wv;
      m_pc = m.npc;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] ins;
      logic [31:0] din;
      int          pca;
      bit          chk_mem;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [2:0]  mts;
      bit          mw;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [31:0] din,
                               input int pca, input bit cm, input logic [31:0] addr,
                               input logic [31:0] dout, input logic [2:0] mts, input bit mw);
      vec_t t;
      t.name = n; t.ins = ins; t.din = din; t.pca = pca; t.chk_mem = cm;
      t.addr = addr; t.dout = dout; t.mts = mts; t.mw = mw;
      return t;
   endfunction

   task automatic build_table();
      // ALU basics
      tbl.push_back(mk("addi_x1_5",  enc_i(5, 0, 0, 1, 7'b0010011),  0, 0, 1, 32'h5, 0, 3'b010, 0));
      tbl.push_back(mk("addi_x2_m3", enc_i(-3, 0, 0, 2, 7'b0010011), 0, 1, 1, 32'hFFFF_FFFD, 0, 3'b010, 0));
      tbl.push_back(mk("add_x3",     enc_r(7'h00, 2, 1, 0, 3),       0, 2, 1, 32'h2, 0, 3'b010, 0));
      tbl.push_back(mk("sub_x4",     enc_r(7'h20, 2, 1, 0, 4),       0, 3, 1, 32'h8, 0, 3'b010, 0));
      tbl.push_back(mk("sw_x3_8",    enc_s(8, 3, 0, 3'b010),         0, 4, 1, 32'h8, 32'h2, 3'b010, 1));
      tbl.push_back(mk("rd_x4",      enc_s(12, 4, 0, 3'b010),        0, 5, 1, 32'hC, 32'h8, 3'b010, 1));
      // shifts and compares on 0x8000_0000
      tbl.push_back(mk("lui_x1",     enc_u(32'h80000, 1, 7'b0110111), 0, 6, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("srai_x5",    enc_i(32'h404, 1, 5, 5, 7'b0010011), 0, 7, 1, 32'hF800_0000, 0, 3'b010, 0));
      tbl.push_back(mk("srli_x6",    enc_i(4, 1, 5, 6, 7'b0010011),  0, 8, 1, 32'h0800_0000, 0, 3'b010, 0));
      tbl.push_back(mk("slt_x7",     enc_r(7'h00, 0, 1, 2, 7),       0, 9, 1, 32'h1, 0, 3'b010, 0));
      tbl.push_back(mk("sltu_x8",    enc_r(7'h00, 0, 1, 3, 8),       0, 10, 1, 32'h0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x5",      enc_s(0, 5, 0, 3'b010),         0, 11, 1, 0, 32'hF800_0000, 3'b010, 1));
      tbl.push_back(mk("rd_x6",      enc_s(0, 6, 0, 3'b010),         0, 12, 1, 0, 32'h0800_0000, 3'b010, 1));
      tbl.push_back(mk("rd_x7",      enc_s(0, 7, 0, 3'b010),         0, 13, 1, 0, 32'h1, 3'b010, 1));
      tbl.push_back(mk("rd_x8",      enc_s(0, 8, 0, 3'b010),         0, 14, 1, 0, 32'h0, 3'b010, 1));
      // store sizes and loads
      tbl.push_back(mk("sb_x3_9",    enc_s(9, 3, 0, 3'b000),         0, 15, 1, 32'h9, 32'h2, 3'b000, 1));
      tbl.push_back(mk("sh_x3_10",   enc_s(10, 3, 0, 3'b001),        0, 16, 1, 32'hA, 32'h2, 3'b001, 1));
      tbl.push_back(mk("lw_x9",      enc_i(8, 0, 2, 9, 7'b0000011),  32'h1234_5678, 17, 1, 32'h8, 0, 3'b010, 0));
      tbl.push_back(mk("lbu_x10",    enc_i(8, 0, 4, 10, 7'b0000011), 32'h78, 18, 1, 32'h8, 0, 3'b100, 0));
      tbl.push_back(mk("rd_x9",      enc_s(0, 9, 0, 3'b010),         0, 19, 1, 0, 32'h1234_5678, 3'b010, 1));
      tbl.push_back(mk("rd_x10",     enc_s(4, 10, 0, 3'b010),        0, 20, 1, 32'h4, 32'h78, 3'b010, 1));
      // branches
      tbl.push_back(mk("beq_taken",  enc_b(8, 0, 0, 3'b000),         0, 21, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("bne_not",    enc_b(8, 0, 0, 3'b001),         0, 23, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("addi_x1_m1", enc_i(-1, 0, 0, 1, 7'b0010011), 0, 24, 1, 32'hFFFF_FFFF, 0, 3'b010, 0));
      tbl.push_back(mk("addi_x2_1",  enc_i(1, 0, 0, 2, 7'b0010011),  0, 25, 1, 32'h1, 0, 3'b010, 0));
      tbl.push_back(mk("blt_taken",  enc_b(8, 2, 1, 3'b100),         0, 26, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("bltu_not",   enc_b(8, 2, 1, 3'b110),         0, 28, 0, 0, 0, 3'b010, 0));
      // jumps
      tbl.push_back(mk("jalr_to_20", enc_i(32, 0, 0, 0, 7'b1100111), 0, 29, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("jal_x1_16",  enc_j(16, 1),                   0, 8, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x1_link", enc_s(0, 1, 0, 3'b010),         0, 12, 1, 0, 32'h24, 3'b010, 1));
      tbl.push_back(mk("jalr_x1",    enc_i(0, 1, 0, 0, 7'b1100111),  0, 13, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("auipc_x2",   enc_u(32'h1, 2, 7'b0010111),    0, 9, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x2",      enc_s(0, 2, 0, 3'b010),         0, 10, 1, 0, 32'h1024, 3'b010, 1));
      // x0, NOP-class opcodes, JALR with rd==rs1, SLTIU/SLTI with -1
      tbl.push_back(mk("addi_x0_7",  enc_i(7, 0, 0, 0, 7'b0010011),  0, 11, 1, 32'h7, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x0",      enc_s(0, 0, 0, 3'b010),         0, 12, 1, 0, 32'h0, 3'b010, 1));
      tbl.push_back(mk("undef_0",    32'h0000_0000,                  0, 13, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x1_kept", enc_s(4, 1, 0, 3'b010),         0, 14, 1, 32'h4, 32'h24, 3'b010, 1));
      tbl.push_back(mk("jalr_rd_rs1", enc_i(4, 1, 0, 1, 7'b1100111), 0, 15, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x1_jalr", enc_s(0, 1, 0, 3'b010),         0, 10, 1, 0, 32'h40, 3'b010, 1));
      tbl.push_back(mk("sltiu_m1",   enc_i(-1, 0, 3, 12, 7'b0010011), 0, 11, 1, 32'h1, 0, 3'b010, 0));
      tbl.push_back(mk("slti_m1",    enc_i(-1, 0, 2, 13, 7'b0010011), 0, 12, 1, 32'h0, 0, 3'b010, 0));
      tbl.push_back(mk("ecall_nop",  32'h0000_0073,                  0, 13, 0, 0, 0, 3'b010, 0));
      tbl.push_back(mk("rd_x13",     enc_s(0, 13, 0, 3'b010),        0, 14, 1, 0, 32'h0, 3'b010, 1));
      tbl.push_back(mk("rd_x12",     enc_s(0, 12, 0, 3'b010),        0, 15, 1, 0, 32'h1, 3'b010, 1));
   endtask

   // ---------------- random stimulus ----------------
   function automatic logic [31:0] rand_instr();
      int          cls;
      int          imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [2:0]  ld_f3 [5];
      logic [2:0]  br_f3 [6];
      logic [31:0] misc  [5];
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      misc  = '{32'h0000_000F, 32'h0000_0073, 32'h0010_0073, 32'h3000_22F3, 32'h0000_02FF};
      cls = int'($urandom_range(0, 11));
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 4095)) - 2048;
      case (cls)
         0, 1, 2: begin
            f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
            return enc_r(f7, rs2, rs1, f3, rd);
         end
         3, 4, 5: begin
            if (f3 == 3'd1) imm = int'($urandom_range(0, 31));
            if (f3 == 3'd5) imm = int'($urandom_range(0, 31)) + (($urandom_range(0, 1) == 1) ? 1024 : 0);
            return enc_i(imm, rs1, f3, rd, 7'b0010011);
         end
         6:  return enc_u($urandom(), rd, ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111);
         7:  return enc_i(imm, rs1, ld_f3[$urandom_range(0, 4)], rd, 7'b0000011);
         8:  return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
         9:  return enc_b((int'($urandom_range(0, 16)) - 8) * 4, rs2, rs1, br_f3[$urandom_range(0, 5)]);
         10: begin
            if ($urandom_range(0, 1) == 1) return enc_j((int'($urandom_range(0, 32)) - 16) * 4, rd);
            return enc_i(int'($urandom_range(0, 64)) - 32, rs1, 3'd0, rd, 7'b1100111);
         end
         default: return misc[$urandom_range(0, 4)];
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b0;
      instruction = NOP;
      Data_in = 32'h0;
      model_reset();
      build_table();

      repeat (4) begin
         @(negedge clk);
         check("reset_pc_addr", PC_Addr, 32'h0);
         check("reset_mem_write", {31'h0, Mem_write}, 32'h0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].ins, tbl[i].din);
         check({tbl[i].name, "_pc"}, s_pca, 32'(tbl[i].pca));
         check({tbl[i].name, "_mts"}, {29'h0, s_mts}, {29'h0, tbl[i].mts});
         check({tbl[i].name, "_mw"}, {31'h0, s_mw}, {31'h0, tbl[i].mw});
         if (tbl[i].chk_mem) check({tbl[i].name, "_addr"}, s_addr, tbl[i].addr);
         if (tbl[i].chk_mem && tbl[i].mw) check({tbl[i].name, "_dout"}, s_dout, tbl[i].dout);
      end

      // Mem_write must drop once the store has retired
      step(NOP, 0);
      check("after_store_mw", {31'h0, s_mw}, 32'h0);

      // asynchronous reset in the middle of a clock period
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check("async_reset_pc_addr", PC_Addr, 32'h0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      step(enc_s(0, 1, 0, 3'b010), 0);
      check("post_reset_pc", s_pca, 32'h0);
      check("post_reset_x1", s_dout, 32'h0);
      step(enc_s(0, 9, 0, 3'b010), 0);
      check("post_reset_x9", s_dout, 32'h0);

      for (int n = 0; n < 400; n++) begin
         step(rand_instr(), $urandom());
         if ((n % 40) == 39) begin
            for (int r = 1; r < 8; r++) step(enc_s(0, 5'(r), 0, 3'b010), 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
